// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_pkg                                                         |
// | Purpose  : Shared timing constants, sync polarity encodings and a helper   |
// |            that derives region boundaries from an active/porch/sync set.   |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial parametrised release                              |
// +----------------------------------------------------------------------------+
package vga_pkg;

  // Legacy 299x476 timing (384 x 523 total)
  localparam int DEF_H_ACTIVE = 299;
  localparam int DEF_H_FP     = 0;
  localparam int DEF_H_SYNC   = 78;
  localparam int DEF_H_BP     = 7;
  localparam int DEF_V_ACTIVE = 476;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 46;
  localparam int DEF_V_BP     = 0;

  // 640x480 @ 25 MHz preset (800 x 525 total)
  localparam int P640_H_ACTIVE = 640;
  localparam int P640_H_FP     = 16;
  localparam int P640_H_SYNC   = 96;
  localparam int P640_H_BP     = 48;
  localparam int P640_V_ACTIVE = 480;
  localparam int P640_V_FP     = 10;
  localparam int P640_V_SYNC   = 2;
  localparam int P640_V_BP     = 33;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  // Inclusive sync bounds plus the last count value of the axis.
  typedef struct packed {
    int sync_first;
    int sync_last;
    int last;
  } vga_bounds_t;

  function automatic vga_bounds_t vga_bounds(input int active, input int fp,
                                             input int sync, input int bp);
    vga_bounds_t b;
    b.sync_first = active + fp;
    b.sync_last  = active + fp + sync - 1;
    b.last       = active + fp + sync + bp - 1;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_axis_cnt                                                    |
// | Purpose  : One wrapping timing axis (h or v). Regions in count order:      |
// |            active, front porch, sync, back porch.                          |
// | Ports    : clk, reset     - clock, synchronous active-high reset           |
// |            i_adv          - advance the count by one                       |
// |            o_count        - current count 0..TOTAL-1                       |
// |            o_in_active    - count lies in the active region                |
// |            o_sync_level   - sync line level for the current count          |
// |            o_wrap         - count is at its last value                     |
// | Revision : 1.0 - initial parametrised release                              |
// +----------------------------------------------------------------------------+
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int   ACTIVE = DEF_H_ACTIVE,
  parameter int   FP     = DEF_H_FP,
  parameter int   SYNC   = DEF_H_SYNC,
  parameter int   BP     = DEF_H_BP,
  parameter logic POL    = SYNC_ACTIVE_LOW,
  localparam int  TOTAL  = ACTIVE + FP + SYNC + BP,
  localparam int  W      = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_adv,
  output logic [W-1:0] o_count,
  output logic         o_in_active,
  output logic         o_sync_level,
  output logic         o_wrap
);

  localparam vga_bounds_t    C_B          = vga_bounds(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0]   C_LAST       = W'(C_B.last);
  localparam logic [W-1:0]   C_SYNC_FIRST = W'(C_B.sync_first);
  localparam logic [W-1:0]   C_SYNC_LAST  = W'(C_B.sync_last);
  localparam logic [W-1:0]   C_ACTIVE     = W'(ACTIVE);

  generate
    if (SYNC < 1) begin : g_bad_sync
      $error("vga_axis_cnt: SYNC width must be at least 1");
    end
  endgenerate

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_adv) begin
      r_count <= (r_count == C_LAST) ? '0 : r_count + W'(1);
    end
  end

  assign o_count      = r_count;
  assign o_wrap       = (r_count == C_LAST);
  assign o_in_active  = (r_count < C_ACTIVE);
  // Inclusive upper bound keeps the compare in range when the sync region
  // ends exactly at TOTAL (zero back porch).
  assign o_sync_level = ((r_count >= C_SYNC_FIRST) && (r_count <= C_SYNC_LAST))
                        ? POL : ~POL;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_timing_gen                                                  |
// | Purpose  : Parametrised VGA timing generator with pixel-clock divider,     |
// |            registered and mutually aligned sync/position/strobe outputs    |
// |            and a wrapping frame counter.                                   |
// | Ports    : clk, reset   - clock, synchronous active-high reset             |
// |            pix_ce       - high in each clk where a new pixel is presented  |
// |            h_sync/v_sync- syncs at the configured polarity                 |
// |            h_pos/v_pos  - active-area coordinates, 0 outside it            |
// |            vga_enable   - pixel is inside the active area                  |
// |            line_start   - first active pixel of an active line             |
// |            frame_start  - pixel (0,0)                                      |
// |            frame_cnt    - frames completed since reset (wraps)             |
// | Revision : 1.0 - initial parametrised release                              |
// +----------------------------------------------------------------------------+
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FP       = DEF_H_FP,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BP       = DEF_H_BP,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FP       = DEF_V_FP,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BP       = DEF_V_BP,
  parameter logic H_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter logic V_SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int   PIX_DIV    = 1,
  parameter int   FRAME_W    = 8,
  localparam int  H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  H_W        = $clog2(H_TOTAL),
  localparam int  V_W        = $clog2(V_TOTAL),
  localparam int  HP_W       = $clog2(H_ACTIVE),
  localparam int  VP_W       = $clog2(V_ACTIVE)
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pix_ce,
  output logic               h_sync,
  output logic               v_sync,
  output logic [HP_W-1:0]    h_pos,
  output logic [VP_W-1:0]    v_pos,
  output logic               vga_enable,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int               DIV_W      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(PIX_DIV - 1);

  generate
    if (PIX_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: PIX_DIV must be at least 1");
    end
  endgenerate

  // Pixel-clock divider; restarts on reset so no partial period follows it.
  logic [DIV_W-1:0] r_div_cnt;
  logic             w_ce;

  assign w_ce = (r_div_cnt == C_DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= w_ce ? '0 : r_div_cnt + DIV_W'(1);
    end
  end

  logic [H_W-1:0] w_h_cnt;
  logic [V_W-1:0] w_v_cnt;
  logic           w_h_act, w_v_act, w_h_lvl, w_v_lvl, w_h_wrap, w_v_wrap;
  logic           w_active;

  vga_axis_cnt #(
    .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .POL (H_SYNC_POL)
  ) u_h_cnt (
    .clk          (clk),
    .reset        (reset),
    .i_adv        (w_ce),
    .o_count      (w_h_cnt),
    .o_in_active  (w_h_act),
    .o_sync_level (w_h_lvl),
    .o_wrap       (w_h_wrap)
  );

  vga_axis_cnt #(
    .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .POL (V_SYNC_POL)
  ) u_v_cnt (
    .clk          (clk),
    .reset        (reset),
    .i_adv        (w_ce & w_h_wrap),
    .o_count      (w_v_cnt),
    .o_in_active  (w_v_act),
    .o_sync_level (w_v_lvl),
    .o_wrap       (w_v_wrap)
  );

  assign w_active = w_h_act & w_v_act;

  logic               r_pix_ce, r_h_sync, r_v_sync;
  logic [HP_W-1:0]    r_h_pos;
  logic [VP_W-1:0]    r_v_pos;
  logic               r_vga_enable, r_line_start, r_frame_start;
  logic [FRAME_W-1:0] r_frame_cnt;

  // Every output is captured from the same counter state on the same edge,
  // so they all describe one pixel. pix_ce marks the clk in which that new
  // pixel is first visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix_ce      <= 1'b0;
      r_h_sync      <= ~H_SYNC_POL;
      r_v_sync      <= ~V_SYNC_POL;
      r_h_pos       <= '0;
      r_v_pos       <= '0;
      r_vga_enable  <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_pix_ce <= w_ce;
      if (w_ce) begin
        r_h_sync      <= w_h_lvl;
        r_v_sync      <= w_v_lvl;
        r_vga_enable  <= w_active;
        r_h_pos       <= w_active ? w_h_cnt[HP_W-1:0] : '0;
        r_v_pos       <= w_active ? w_v_cnt[VP_W-1:0] : '0;
        r_line_start  <= w_active & (w_h_cnt == '0);
        r_frame_start <= (w_h_cnt == '0) & (w_v_cnt == '0);
        if (w_h_wrap & w_v_wrap) begin
          r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
        end
      end
    end
  end

  assign pix_ce      = r_pix_ce;
  assign h_sync      = r_h_sync;
  assign v_sync      = r_v_sync;
  assign h_pos       = r_h_pos;
  assign v_pos       = r_v_pos;
  assign vga_enable  = r_vga_enable;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vga_timing_gen                                               |
// | Purpose  : Self-checking bench for vga_timing_gen. Three instances:        |
// |            legacy defaults, 640x480 preset with PIX_DIV=2, and a small     |
// |            active-high / PIX_DIV=3 / FRAME_W=2 configuration.              |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_vga_timing_gen;

  typedef struct packed {
    logic        pix_ce;
    logic        hs;
    logic        vs;
    logic [15:0] hpos;
    logic [15:0] vpos;
    logic        en;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
  } obs_t;

  typedef struct packed {
    int   ha, hfp, hs, hbp;
    int   va, vfp, vs, vbp;
    int   div, fw;
    logic hpol, vpol;
  } cfg_t;

  typedef struct packed {
    int   div, h, v, fc;
    obs_t e;
  } mst_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d = 1'b1, rst_v = 1'b1, rst_s = 1'b1;

  // Legacy defaults
  logic       d_ce, d_hs, d_vs, d_en, d_ls, d_fs;
  logic [8:0] d_hpos, d_vpos;
  logic [7:0] d_fc;
  vga_timing_gen u_def (
    .clk (clk), .reset (rst_d), .pix_ce (d_ce), .h_sync (d_hs), .v_sync (d_vs),
    .h_pos (d_hpos), .v_pos (d_vpos), .vga_enable (d_en), .line_start (d_ls),
    .frame_start (d_fs), .frame_cnt (d_fc)
  );

  // 640x480 preset, PIX_DIV=2
  logic       v_ce, v_hs, v_vs, v_en, v_ls, v_fs;
  logic [9:0] v_hpos;
  logic [8:0] v_vpos;
  logic [7:0] v_fc;
  vga_timing_gen #(
    .H_ACTIVE (640), .H_FP (16), .H_SYNC (96), .H_BP (48),
    .V_ACTIVE (480), .V_FP (10), .V_SYNC (2),  .V_BP (33),
    .H_SYNC_POL (1'b0), .V_SYNC_POL (1'b0), .PIX_DIV (2), .FRAME_W (8)
  ) u_vga (
    .clk (clk), .reset (rst_v), .pix_ce (v_ce), .h_sync (v_hs), .v_sync (v_vs),
    .h_pos (v_hpos), .v_pos (v_vpos), .vga_enable (v_en), .line_start (v_ls),
    .frame_start (v_fs), .frame_cnt (v_fc)
  );

  // Small: 9 x 6 total, active-high syncs, PIX_DIV=3, FRAME_W=2
  logic       s_ce, s_hs, s_vs, s_en, s_ls, s_fs;
  logic [2:0] s_hpos;
  logic [1:0] s_vpos;
  logic [1:0] s_fc;
  vga_timing_gen #(
    .H_ACTIVE (6), .H_FP (0), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (0),
    .H_SYNC_POL (1'b1), .V_SYNC_POL (1'b1), .PIX_DIV (3), .FRAME_W (2)
  ) u_s (
    .clk (clk), .reset (rst_s), .pix_ce (s_ce), .h_sync (s_hs), .v_sync (s_vs),
    .h_pos (s_hpos), .v_pos (s_vpos), .vga_enable (s_en), .line_start (s_ls),
    .frame_start (s_fs), .frame_cnt (s_fc)
  );

  obs_t obs_d, obs_v, obs_s;
  assign obs_d = {d_ce, d_hs, d_vs, 16'(d_hpos), 16'(d_vpos), d_en, d_ls, d_fs, 8'(d_fc)};
  assign obs_v = {v_ce, v_hs, v_vs, 16'(v_hpos), 16'(v_vpos), v_en, v_ls, v_fs, 8'(v_fc)};
  assign obs_s = {s_ce, s_hs, s_vs, 16'(s_hpos), 16'(s_vpos), s_en, s_ls, s_fs, 8'(s_fc)};

  cfg_t cfg_d, cfg_v, cfg_s;
  mst_t st_d, st_v, st_s;
  obs_t q_d[$], q_v[$], q_s[$];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t reset_obs(input cfg_t c);
    obs_t o;
    o    = '0;
    o.hs = ~c.hpol;
    o.vs = ~c.vpol;
    return o;
  endfunction

  // Reference model: expected registered outputs after one clk edge.
  function automatic mst_t model_step(input mst_t s, input cfg_t c, input logic rst);
    mst_t n;
    int   ht, vt;
    n  = s;
    ht = c.ha + c.hfp + c.hs + c.hbp;
    vt = c.va + c.vfp + c.vs + c.vbp;
    if (rst) begin
      n.div = 0; n.h = 0; n.v = 0; n.fc = 0;
      n.e   = reset_obs(c);
    end else if (s.div != c.div - 1) begin
      n.div      = s.div + 1;
      n.e.pix_ce = 1'b0;
    end else begin
      n.div      = 0;
      n.e.pix_ce = 1'b1;
      n.e.hs     = (s.h >= c.ha + c.hfp && s.h < c.ha + c.hfp + c.hs) ? c.hpol : ~c.hpol;
      n.e.vs     = (s.v >= c.va + c.vfp && s.v < c.va + c.vfp + c.vs) ? c.vpol : ~c.vpol;
      n.e.en     = (s.h < c.ha) && (s.v < c.va);
      n.e.hpos   = n.e.en ? 16'(s.h) : 16'd0;
      n.e.vpos   = n.e.en ? 16'(s.v) : 16'd0;
      n.e.ls     = n.e.en && (s.h == 0);
      n.e.fs     = (s.h == 0) && (s.v == 0);
      if (s.h == ht - 1 && s.v == vt - 1) n.fc = (s.fc + 1) % (1 << c.fw);
      n.e.fc     = 8'(n.fc);
      n.h        = (s.h == ht - 1) ? 0 : s.h + 1;
      if (s.h == ht - 1) n.v = (s.v == vt - 1) ? 0 : s.v + 1;
    end
    return n;
  endfunction

  // One clk: step every model with the reset each DUT sees and push the
  // expected outputs; return at the negedge where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    st_d = model_step(st_d, cfg_d, rst_d); q_d.push_back(st_d.e);
    st_v = model_step(st_v, cfg_v, rst_v); q_v.push_back(st_v.e);
    st_s = model_step(st_s, cfg_s, rst_s); q_s.push_back(st_s.e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_d = 1'b1; rst_v = 1'b1; rst_s = 1'b1;
    repeat (3) tick();
    checks++;
    if (obs_d !== reset_obs(cfg_d)) begin
      errors++; $display("FAIL reset_def got %h exp %h", obs_d, reset_obs(cfg_d));
    end
    checks++;
    if (obs_v !== reset_obs(cfg_v)) begin
      errors++; $display("FAIL reset_vga got %h exp %h", obs_v, reset_obs(cfg_v));
    end
    checks++;
    if (obs_s !== reset_obs(cfg_s)) begin
      errors++; $display("FAIL reset_small got %h exp %h", obs_s, reset_obs(cfg_s));
    end
    q_d.delete(); q_v.delete(); q_s.delete();
  endtask

  task automatic test_default_timing();
    obs_t e;
    int   last_fall, period, low_w, en_cnt, en_line, hmax, bad_pos, bad_fs, fs_n;
    logic prev_hs, prev_en;
    last_fall = -1; period = -1; low_w = -1; en_cnt = 0; en_line = -1;
    hmax = 0; bad_pos = 0; bad_fs = 0; fs_n = 0;
    prev_hs = d_hs; prev_en = d_en;
    q_d.delete();
    rst_d = 1'b0;
    for (int t = 0; t < 2 * 384 + 100; t++) begin
      tick();
      e = q_d.pop_front();
      checks++;
      if (obs_d !== e) begin
        errors++; $display("FAIL sb_def t=%0d got %h exp %h", t, obs_d, e);
      end
      if (t == 0) begin
        checks++;
        if (d_fs !== 1'b1 || d_ls !== 1'b1) begin
          errors++; $display("FAIL def_first_pixel fs=%b ls=%b exp 1 1", d_fs, d_ls);
        end
      end
      if (prev_hs && !d_hs) begin
        if (last_fall >= 0) period = t - last_fall;
        last_fall = t;
      end
      if (!prev_hs && d_hs && last_fall >= 0) low_w = t - last_fall;
      if (d_en) en_cnt++;
      if (prev_en && !d_en) begin en_line = en_cnt; en_cnt = 0; end
      if (d_en && int'(d_hpos) > hmax) hmax = int'(d_hpos);
      if (!d_en && (d_hpos != 0 || d_vpos != 0)) bad_pos++;
      if (d_fs) begin
        fs_n++;
        if (!(d_en && d_hpos == 0 && d_vpos == 0)) bad_fs++;
      end
      prev_hs = d_hs; prev_en = d_en;
    end
    checks++;
    if (period != 384) begin errors++; $display("FAIL def_hsync_period got %0d exp 384", period); end
    checks++;
    if (low_w != 78) begin errors++; $display("FAIL def_hsync_low got %0d exp 78", low_w); end
    checks++;
    if (en_line != 299) begin errors++; $display("FAIL def_enable_per_line got %0d exp 299", en_line); end
    checks++;
    if (hmax != 298) begin errors++; $display("FAIL def_hpos_max got %0d exp 298", hmax); end
    checks++;
    if (bad_pos != 0) begin errors++; $display("FAIL def_pos_outside got %0d exp 0", bad_pos); end
    checks++;
    if (fs_n != 1 || bad_fs != 0) begin
      errors++; $display("FAIL def_frame_start count=%0d bad=%0d exp 1 0", fs_n, bad_fs);
    end
  endtask

  task automatic test_preset_div2();
    obs_t e, cur, prev;
    int   last_fall, period, low_w, ce_bad, stab_bad;
    logic prev_hs, prev_ce;
    last_fall = -1; period = -1; low_w = -1; ce_bad = 0; stab_bad = 0;
    prev_hs = v_hs; prev_ce = v_ce;
    prev = obs_v; prev.pix_ce = 1'b0;
    q_v.delete();
    rst_v = 1'b0;
    for (int t = 0; t < 3 * 1600 + 50; t++) begin
      tick();
      e = q_v.pop_front();
      checks++;
      if (obs_v !== e) begin
        errors++; $display("FAIL sb_vga t=%0d got %h exp %h", t, obs_v, e);
      end
      cur = obs_v; cur.pix_ce = 1'b0;
      if (t > 0 && v_ce == prev_ce) ce_bad++;
      if (!v_ce && cur != prev) stab_bad++;
      if (prev_hs && !v_hs) begin
        if (last_fall >= 0) period = t - last_fall;
        last_fall = t;
      end
      if (!prev_hs && v_hs && last_fall >= 0) low_w = t - last_fall;
      prev_hs = v_hs; prev_ce = v_ce; prev = cur;
    end
    checks++;
    if (period != 1600) begin errors++; $display("FAIL vga_line_clk got %0d exp 1600", period); end
    checks++;
    if (low_w != 192) begin errors++; $display("FAIL vga_hsync_low_clk got %0d exp 192", low_w); end
    checks++;
    if (ce_bad != 0) begin errors++; $display("FAIL vga_pix_ce_cadence bad=%0d exp 0", ce_bad); end
    checks++;
    if (stab_bad != 0) begin errors++; $display("FAIL vga_stable_between_ce bad=%0d exp 0", stab_bad); end
  endtask

  task automatic test_polarity_frames();
    obs_t e;
    int   fc_seen[6];
    int   nfs, hs_rise, hs_w, vs_rise, vs_w, vmax, hmax;
    logic prev_hs, prev_vs, pend;
    logic [1:0] prev_fc;
    int   exp_fc[6] = '{0, 1, 2, 3, 0, 1};
    nfs = 0; hs_rise = -1; hs_w = -1; vs_rise = -1; vs_w = -1; vmax = 0; hmax = 0;
    prev_hs = s_hs; prev_vs = s_vs; prev_fc = s_fc; pend = 1'b0;
    q_s.delete();
    rst_s = 1'b0;
    for (int t = 0; t < 5 * 162 + 20; t++) begin
      tick();
      e = q_s.pop_front();
      checks++;
      if (obs_s !== e) begin
        errors++; $display("FAIL sb_small t=%0d got %h exp %h", t, obs_s, e);
      end
      if (pend && s_ce) begin
        checks++;
        if (s_fs !== 1'b1) begin
          errors++; $display("FAIL small_fc_before_fs t=%0d fs=%b exp 1", t, s_fs);
        end
        pend = 1'b0;
      end
      if (s_fc != prev_fc) pend = 1'b1;
      if (s_fs && s_ce && nfs < 6) begin fc_seen[nfs] = int'(s_fc); nfs++; end
      if (!prev_hs && s_hs) hs_rise = t;
      if (prev_hs && !s_hs && hs_rise >= 0) hs_w = t - hs_rise;
      if (!prev_vs && s_vs) vs_rise = t;
      if (prev_vs && !s_vs && vs_rise >= 0) vs_w = t - vs_rise;
      if (s_en && int'(s_vpos) > vmax) vmax = int'(s_vpos);
      if (s_en && int'(s_hpos) > hmax) hmax = int'(s_hpos);
      prev_hs = s_hs; prev_vs = s_vs; prev_fc = s_fc;
    end
    checks++;
    if (nfs != 6) begin errors++; $display("FAIL small_frame_starts got %0d exp 6", nfs); end
    for (int i = 0; i < 6; i++) begin
      if (i < nfs) begin
        checks++;
        if (fc_seen[i] != exp_fc[i]) begin
          errors++; $display("FAIL small_frame_cnt[%0d] got %0d exp %0d", i, fc_seen[i], exp_fc[i]);
        end
      end
    end
    checks++;
    if (hs_w != 6) begin errors++; $display("FAIL small_hsync_high_clk got %0d exp 6", hs_w); end
    checks++;
    if (vs_w != 27) begin errors++; $display("FAIL small_vsync_high_clk got %0d exp 27", vs_w); end
    checks++;
    if (vmax != 3 || hmax != 5) begin
      errors++; $display("FAIL small_pos_max got h=%0d v=%0d exp h=5 v=3", hmax, vmax);
    end
  endtask

  task automatic test_reset_midframe();
    obs_t e;
    logic found;
    int   fs_at;
    found = 1'b0;
    fs_at = -1;
    q_s.delete();
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      e = q_s.pop_front();
      checks++;
      if (obs_s !== e) begin
        errors++; $display("FAIL sb_mid_pre i=%0d got %h exp %h", i, obs_s, e);
      end
      if (st_s.h == 4 && st_s.v == 2 && st_s.div == 1) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL mid_reach_point got 0 exp 1"); end
    rst_s = 1'b1;
    tick();
    e = q_s.pop_front();
    checks++;
    if (obs_s !== reset_obs(cfg_s) || obs_s !== e) begin
      errors++; $display("FAIL mid_reset_values got %h exp %h", obs_s, reset_obs(cfg_s));
    end
    rst_s = 1'b0;
    for (int t = 1; t <= 8 && fs_at < 0; t++) begin
      tick();
      e = q_s.pop_front();
      checks++;
      if (obs_s !== e) begin
        errors++; $display("FAIL sb_mid_post t=%0d got %h exp %h", t, obs_s, e);
      end
      if (s_fs) fs_at = t;
    end
    checks++;
    if (fs_at != 3) begin errors++; $display("FAIL mid_fs_latency got %0d exp 3", fs_at); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_d = '{ha: 299, hfp: 0,  hs: 78, hbp: 7,  va: 476, vfp: 1,  vs: 46, vbp: 0,
              div: 1, fw: 8, hpol: 1'b0, vpol: 1'b0};
    cfg_v = '{ha: 640, hfp: 16, hs: 96, hbp: 48, va: 480, vfp: 10, vs: 2,  vbp: 33,
              div: 2, fw: 8, hpol: 1'b0, vpol: 1'b0};
    cfg_s = '{ha: 6,   hfp: 0,  hs: 2,  hbp: 1,  va: 4,   vfp: 1,  vs: 1,  vbp: 0,
              div: 3, fw: 2, hpol: 1'b1, vpol: 1'b1};
    st_d = '0; st_v = '0; st_s = '0;
    test_reset();
    test_default_timing();
    test_preset_div2();
    test_polarity_frames();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
